axi_wr_mem_slave: RTL and testbench

AXI4 write-only memory slave that sits directly downstream of the AHB-to-AXI bridge. It consumes the AW, W and B channels and stores write data into an internal byte-strobed SRAM array. It exists so the bridge can be exercised closed-loop without an external interconnect. A combinational backdoor read port gives the verification bench access to memory contents.

---
 rtl/axi_pkg.sv | 30 +++
 rtl/axi_burst_addr_gen.sv | 32 +++
 rtl/axi_wr_mem_slave.sv | 171 +++++++++++++++++
 tb/tb_axi_wr_mem_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and write-slave state type.
// Also holds the helper that checks whether a WRAP burst length is legal.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_state_t;

    localparam logic [1:0] BURST_RSVD = 2'b11;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
// INCR is deliberately not clamped at 4KB; the reserved burst type holds the address.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] step;
    logic [AW-1:0] incr_addr;
    logic [AW-1:0] wrap_mask;

    always_comb begin
        step      = AW'(1) << size;
        incr_addr = addr + step;
        // Wrap window is (len+1)<<size bytes, aligned to its own size
        wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_mem_slave.sv
// AXI4 write-only memory slave: AW/W/B channels into a byte-strobed array,
// one transaction outstanding, plus a combinational backdoor read port.
module axi_wr_mem_slave
    import axi_pkg::*;
#(
    parameter int unsigned TIDW      = 1,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 64,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned B_LAT     = 1
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [TIDW-1:0]              axi_aw_id_i,
    input  logic [AW-1:0]                axi_aw_addr_i,
    input  logic [7:0]                   axi_aw_len_i,
    input  logic [2:0]                   axi_aw_size_i,
    input  logic [1:0]                   axi_aw_burst_i,
    input  logic                         axi_aw_valid_i,
    output logic                         axi_aw_ready_o,
    input  logic [DW-1:0]                axi_w_data_i,
    input  logic [DW/8-1:0]              axi_w_strb_i,
    input  logic                         axi_w_last_i,
    input  logic                         axi_w_valid_i,
    output logic                         axi_w_ready_o,
    output logic [TIDW-1:0]              axi_b_id_o,
    output logic [1:0]                   axi_b_resp_o,
    output logic                         axi_b_valid_o,
    input  logic                         axi_b_ready_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr_i,
    output logic [DW-1:0]                dbg_rdata_o
);

    localparam int unsigned SB  = DW / 8;
    localparam int unsigned LB  = $clog2(SB);
    localparam int unsigned IW  = $clog2(MEM_DEPTH);
    localparam int unsigned AWX = AW + 1;
    localparam logic [AW:0] MEM_BYTES = AWX'(MEM_DEPTH * SB);
    localparam logic [3:0]  LAT_LOAD  = 4'(B_LAT - 1);

    logic [DW-1:0] mem [MEM_DEPTH];

    wr_state_t       state;
    logic [TIDW-1:0] id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [7:0]      cnt;
    logic            err;
    logic [3:0]      lat;

    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            aw_err;
    logic            beat_in_range;
    logic            last_beat;
    logic            beat_err;
    logic            mem_we;
    logic [IW-1:0]   word_idx;
    logic [AW-1:0]   next_addr;

    axi_burst_addr_gen #(
        .AW(AW)
    ) u_addr_gen (
        .addr      (addr),
        .size      (size),
        .len       (len),
        .burst     (burst),
        .next_addr (next_addr)
    );

    always_comb begin
        aw_hs         = axi_aw_valid_i & axi_aw_ready_o;
        w_hs          = axi_w_valid_i & axi_w_ready_o;
        b_hs          = axi_b_valid_o & axi_b_ready_i;
        aw_err        = ({1'b0, axi_aw_addr_i} >= MEM_BYTES)
                      | (axi_aw_size_i > 3'(LB))
                      | (axi_aw_burst_i == BURST_RSVD)
                      | ((axi_aw_burst_i == WRAP) & ~wrap_len_ok(axi_aw_len_i));
        beat_in_range = {1'b0, addr} < MEM_BYTES;
        last_beat     = (cnt == len);
        beat_err      = ~beat_in_range | (axi_w_last_i != last_beat);
        mem_we        = w_hs & ~err & beat_in_range;
        word_idx      = addr[LB +: IW];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state          <= IDLE;
            axi_aw_ready_o <= 1'b1;
            axi_w_ready_o  <= 1'b0;
            axi_b_valid_o  <= 1'b0;
            axi_b_resp_o   <= OKAY;
            axi_b_id_o     <= '0;
            id             <= '0;
            addr           <= '0;
            len            <= '0;
            size           <= '0;
            burst          <= '0;
            cnt            <= '0;
            err            <= 1'b0;
            lat            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        id             <= axi_aw_id_i;
                        addr           <= axi_aw_addr_i;
                        len            <= axi_aw_len_i;
                        size           <= axi_aw_size_i;
                        burst          <= axi_aw_burst_i;
                        cnt            <= '0;
                        err            <= aw_err;
                        axi_aw_ready_o <= 1'b0;
                        axi_w_ready_o  <= 1'b1;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        addr <= next_addr;
                        cnt  <= cnt + 8'd1;
                        err  <= err | beat_err;
                        if (last_beat) begin
                            axi_w_ready_o <= 1'b0;
                            // Counter holds B_LAT-1 so B_LAT=1 raises BVALID on this same edge
                            lat           <= LAT_LOAD;
                            if (B_LAT == 1) begin
                                axi_b_valid_o <= 1'b1;
                                axi_b_id_o    <= id;
                                axi_b_resp_o  <= (err | beat_err) ? SLVERR : OKAY;
                            end
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (!axi_b_valid_o) begin
                        lat <= lat - 4'd1;
                        if (lat == 4'd1) begin
                            axi_b_valid_o <= 1'b1;
                            axi_b_id_o    <= id;
                            axi_b_resp_o  <= err ? SLVERR : OKAY;
                        end
                    end else if (b_hs) begin
                        axi_b_valid_o  <= 1'b0;
                        axi_aw_ready_o <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is intentionally outside the reset domain so contents survive reset
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < SB; i++) begin
                if (axi_w_strb_i[i]) begin
                    mem[word_idx][i*8 +: 8] <= axi_w_data_i[i*8 +: 8];
                end
            end
        end
    end

    assign dbg_rdata_o = mem[dbg_addr_i];

endmodule

// File: tb/tb_axi_wr_mem_slave.sv
// Self-checking bench for axi_wr_mem_slave: B responses scoreboarded in a queue,
// memory contents checked through the backdoor port against a byte-level model.
module tb_axi_wr_mem_slave;
    import axi_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic [0:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [0:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [9:0]  dbg_addr;
    logic [63:0] dbg_rdata;

    typedef struct packed {
        logic [0:0] id;
        logic [1:0] resp;
    } b_exp_t;

    b_exp_t      sb[$];
    logic [63:0] model [1024];
    bit          known [1024];
    int          n_checks = 0;
    int          n_pass   = 0;

    axi_wr_mem_slave #(
        .TIDW(1),
        .AW(32),
        .DW(64),
        .MEM_DEPTH(1024),
        .B_LAT(1)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .axi_aw_id_i    (aw_id),
        .axi_aw_addr_i  (aw_addr),
        .axi_aw_len_i   (aw_len),
        .axi_aw_size_i  (aw_size),
        .axi_aw_burst_i (aw_burst),
        .axi_aw_valid_i (aw_valid),
        .axi_aw_ready_o (aw_ready),
        .axi_w_data_i   (w_data),
        .axi_w_strb_i   (w_strb),
        .axi_w_last_i   (w_last),
        .axi_w_valid_i  (w_valid),
        .axi_w_ready_o  (w_ready),
        .axi_b_id_o     (b_id),
        .axi_b_resp_o   (b_resp),
        .axi_b_valid_o  (b_valid),
        .axi_b_ready_i  (b_ready),
        .dbg_addr_i     (dbg_addr),
        .dbg_rdata_o    (dbg_rdata)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_aw(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp);
        int n = 0;
        aw_id    = id;
        aw_addr  = addr;
        aw_len   = len;
        aw_size  = size;
        aw_burst = burst;
        aw_valid = 1'b1;
        while (!aw_ready && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        check_eq("aw_accept", aw_ready, 1'b1);
        check_eq("w_stall", w_ready, 1'b0);
        @(negedge HCLK);
        aw_valid = 1'b0;
        check_eq("w_open", {aw_ready, w_ready}, 2'b01);
        sb.push_back('{id: id, resp: exp_resp});
    endtask

    task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last, input int word);
        int n = 0;
        w_data  = data;
        w_strb  = strb;
        w_last  = last;
        w_valid = 1'b1;
        while (!w_ready && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        check_eq("w_accept", w_ready, 1'b1);
        @(negedge HCLK);
        w_valid = 1'b0;
        w_last  = 1'b0;
        if (word >= 0) begin
            for (int b = 0; b < 8; b++)
                if (strb[b]) model[word][b*8 +: 8] = data[b*8 +: 8];
            known[word] = 1'b1;
        end
    endtask

    task automatic do_b(input int hold);
        b_exp_t e;
        check_eq("b_lat", b_valid, 1'b1);
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1'b0, 1'b1);
        end else begin
            e = sb.pop_front();
            check_eq("b_id", b_id, e.id);
            check_eq("b_resp", b_resp, e.resp);
            for (int i = 0; i < hold; i++) begin
                @(negedge HCLK);
                check_eq("b_hold", {b_valid, b_resp, b_id, aw_ready}, {1'b1, e.resp, e.id, 1'b0});
            end
        end
        b_ready = 1'b1;
        @(negedge HCLK);
        b_ready = 1'b0;
        check_eq("b_done", {b_valid, aw_ready}, 2'b01);
    endtask

    task automatic chk_mem(input int word);
        dbg_addr = 10'(word);
        #1;
        if (known[word]) check_eq($sformatf("mem%0d", word), dbg_rdata, model[word]);
    endtask

    initial begin
        HRESETn  = 1'b0;
        aw_id    = '0;
        aw_addr  = '0;
        aw_len   = '0;
        aw_size  = '0;
        aw_burst = '0;
        aw_valid = 1'b0;
        w_data   = '0;
        w_strb   = '0;
        w_last   = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        dbg_addr = '0;
        repeat (2) @(negedge HCLK);
        check_eq("rst_aw_ready", aw_ready, 1'b1);
        check_eq("rst_w_ready", w_ready, 1'b0);
        check_eq("rst_b_valid", b_valid, 1'b0);
        check_eq("rst_b_resp", b_resp, 2'b00);
        check_eq("rst_b_id", b_id, 1'b0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Single write, W presented together with AW
        w_valid = 1'b1;
        w_data  = 64'hDEADBEEF_CAFEF00D;
        w_strb  = 8'hFF;
        w_last  = 1'b1;
        do_aw(1'b1, 32'h10, 8'd0, 3'd3, INCR, OKAY);
        w_beat(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 2);
        do_b(0);
        chk_mem(2);

        // Partial strobe
        do_aw(1'b0, 32'h10, 8'd0, 3'd3, INCR, OKAY);
        w_beat(64'h11223344_55667788, 8'h0F, 1'b1, 2);
        do_b(0);
        chk_mem(2);
        check_eq("strb_lit", dbg_rdata, 64'hDEADBEEF_55667788);

        // INCR4 at 0, then WRAP4 at 0x18
        do_aw(1'b1, 32'h0, 8'd3, 3'd3, INCR, OKAY);
        for (int i = 0; i < 4; i++)
            w_beat(64'hA0A0_0000_0000_0000 | 64'(i), 8'hFF, i == 3, i);
        do_b(0);
        for (int i = 0; i < 4; i++) chk_mem(i);
        do_aw(1'b0, 32'h18, 8'd3, 3'd3, WRAP, OKAY);
        w_beat(64'hB0B0_0000_0000_0003, 8'hFF, 1'b0, 3);
        w_beat(64'hB0B0_0000_0000_0000, 8'hFF, 1'b0, 0);
        w_beat(64'hB0B0_0000_0000_0001, 8'hFF, 1'b0, 1);
        w_beat(64'hB0B0_0000_0000_0002, 8'hFF, 1'b1, 2);
        do_b(0);
        for (int i = 0; i < 4; i++) chk_mem(i);

        // FIXED burst hits the same word twice
        do_aw(1'b1, 32'h20, 8'd1, 3'd3, FIXED, OKAY);
        w_beat(64'h0102_0304_0506_0708, 8'hFF, 1'b0, 4);
        w_beat(64'hF0F0_F0F0_A1A2_A3A4, 8'h0F, 1'b1, 4);
        do_b(0);
        chk_mem(4);

        // Out-of-range address
        do_aw(1'b0, 32'h2000, 8'd0, 3'd3, INCR, SLVERR);
        w_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b1, -1);
        do_b(0);
        for (int i = 0; i < 4; i++) chk_mem(i);

        // Oversized beat, reserved burst, illegal WRAP length
        do_aw(1'b1, 32'h20, 8'd0, 3'd4, INCR, SLVERR);
        w_beat(64'h6666_6666_6666_6666, 8'hFF, 1'b1, -1);
        do_b(0);
        do_aw(1'b0, 32'h20, 8'd0, 3'd3, BURST_RSVD, SLVERR);
        w_beat(64'h7777_7777_7777_7777, 8'hFF, 1'b1, -1);
        do_b(0);
        do_aw(1'b1, 32'h20, 8'd2, 3'd3, WRAP, SLVERR);
        for (int i = 0; i < 3; i++) w_beat(64'h8888_8888_8888_8888, 8'hFF, i == 2, -1);
        do_b(0);
        chk_mem(4);

        // Highest legal word
        do_aw(1'b1, 32'h1FF8, 8'd0, 3'd3, INCR, OKAY);
        w_beat(64'hC0DE_0000_0000_03FF, 8'hFF, 1'b1, 1023);
        do_b(0);
        chk_mem(1023);

        // Early WLAST: SLVERR, burst still runs 4 beats
        do_aw(1'b0, 32'h40, 8'd3, 3'd3, INCR, SLVERR);
        w_beat(64'h9999_0000_0000_0008, 8'hFF, 1'b0, 8);
        w_beat(64'h9999_0000_0000_0009, 8'hFF, 1'b1, -1);
        w_beat(64'h9999_0000_0000_000A, 8'hFF, 1'b0, -1);
        w_beat(64'h9999_0000_0000_000B, 8'hFF, 1'b0, -1);
        do_b(0);
        chk_mem(8);

        // BREADY back-pressure, then back-to-back AW
        do_aw(1'b1, 32'h48, 8'd0, 3'd3, INCR, OKAY);
        w_beat(64'hABCD_0000_0000_0009, 8'hFF, 1'b1, 9);
        do_b(5);
        do_aw(1'b0, 32'h50, 8'd0, 3'd3, INCR, OKAY);
        w_beat(64'hABCD_0000_0000_000A, 8'hFF, 1'b1, 10);
        do_b(0);
        chk_mem(9);
        chk_mem(10);

        // Reset after two beats of an INCR4
        do_aw(1'b1, 32'h0, 8'd3, 3'd3, INCR, OKAY);
        w_beat(64'hEEEE_0000_0000_0000, 8'hFF, 1'b0, 0);
        w_beat(64'hEEEE_0000_0000_0001, 8'hFF, 1'b0, 1);
        HRESETn = 1'b0;
        #1;
        check_eq("mid_rst_aw_ready", aw_ready, 1'b1);
        check_eq("mid_rst_w_ready", w_ready, 1'b0);
        check_eq("mid_rst_b_valid", b_valid, 1'b0);
        void'(sb.pop_back());
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check_eq("post_rst_state", {aw_ready, w_ready, b_valid}, 3'b100);
        for (int i = 0; i < 4; i++) chk_mem(i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
